// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, samples mid-bit, checks the stop bit and holds one word on valid/ready.
// Define UART_RX_MAJORITY_EN to take every bit sample as a 3-cycle majority of the synchronized line.
module uart_rx #(
  parameter int width      = 8,
  parameter int baud_rate  = 9600,
  parameter int clock_freq = 460800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic [width-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             framing_error,
  output logic             overrun
);

  localparam int P  = clock_freq / baud_rate;
  localparam int H  = P / 2;
  localparam int CW = $clog2(P);
  localparam int BW = (width > 1) ? $clog2(width) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  if (P < 4) begin : g_bad_ratio
    $error("uart_rx: clock_freq / baud_rate must be at least 4");
  end

  logic             rx_meta;
  logic             rxs;
  logic             bit_sample;
  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [width-1:0] sreg;
  logic [width-1:0] sreg_next;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1;
  logic rxs_d2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign bit_sample = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign bit_sample = rxs;
`endif

  // NOTE: every always_comb output gets a full default first, so no latch can be inferred.
  always_comb begin
    sreg_next = sreg >> 1;
    sreg_next[width-1] = bit_sample;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      sreg          <= '0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (valid && ready)
        valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            if (bit_sample) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            sreg <= sreg_next;
            if (bit_idx == BIT_LAST)
              state <= ST_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_sample) begin
              state <= ST_IDLE;
              // A handshake on this same edge frees the holding register for the new word.
              if (!valid || ready) begin
                data  <= sreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART deserializer: the downstream counterpart of the transmitter, consuming its serial `signal` line and producing parallel words. It synchronizes the asynchronous line, finds start bits, samples each bit at mid-bit, checks the stop bit and presents each word on a valid/ready handshake with a one-word holding register. It sits between the external RX pin and the receive buffer or consumer logic.

## Interface
- `width`, default 8: data bits per frame, LSB first.
- `baud_rate`, default 9600: line rate in bits/s.
- `clock_freq`, default 460800: `clock` frequency in Hz. `P = clock_freq / baud_rate` (integer division), `H = P / 2`. `P >= 4` is required; elaboration fails otherwise.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clock`.
- `data`  out  width  received word, stable while `valid`.
- `valid`  out  1  `data` holds an unconsumed word.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `busy`  out  1  a frame is being received (state != IDLE).
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good frame dropped because `valid` was still high.

## Operation
- Two-flop synchronizer on `rx`. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- The bit-tick counter spans 0..P-1 and is `$clog2(P)` bits wide. The bit index spans 0..width-1.
- States:
  - IDLE: `rxs == 0` → START, counter cleared.
  - START: at counter == H-1, sample. Sample 1 → IDLE as a false start; nothing is reported. Sample 0 → DATA, with the counter and bit index cleared.
  - DATA: at counter == P-1, sample the bit into the shift register. The register shifts right and the sampled bit enters the MSB. After bit width-1 → STOP.
  - STOP: at counter == P-1, sample.
    - Sample 1 and `valid == 0`: load `data`, set `valid`, go to IDLE.
    - Sample 1 and `valid == 1`: pulse `overrun`, keep the old `data`, go to IDLE.
    - Sample 0: pulse `framing_error`, go to BREAK.
  - BREAK: wait for `rxs == 1`, then go to IDLE. A held-low line or break condition never retriggers reception.
- `valid` clears on the edge where `valid && ready`.
- If the handshake and a new stop-bit load fall on the same edge, the new word loads and `valid` stays 1. No overrun is reported.
- `ready` has no combinational path to any output.
- Reset, including mid-frame, immediately forces:
  - state IDLE, counters 0, synchronizer 1;
  - `data` = 0;
  - `valid`, `busy`, `framing_error`, `overrun` = 0.

## Timing
- Let T be the first edge at which the FSM sees `rxs == 0` in IDLE. T falls 2–3 cycles after the line falls.
- Sample edges:
  - start bit: T+H;
  - data bit i: T+H+(i+1)·P;
  - stop bit: T+H+(width+1)·P.
- `valid`, `framing_error` and `overrun` update on the stop-sample edge. With defaults (P=48, H=24) that is T+456.
- `busy` is high from T+1 until the edge after the stop sample.
- Back-to-back frames are supported. IDLE is re-entered half a bit before the stop bit ends, so the next start edge is caught.
- Throughput is one word per frame. The consumer has one full frame time to accept before overrun.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - a 3-deep history of `rxs` is kept;
  - every sample (start, data, stop) uses the majority of the current value and the two preceding cycles;
  - IDLE start detection still uses single-cycle `rxs`.
- Undefined:
  - every sample uses the single value of `rxs` at the sample edge;
  - no history registers are built.

## Test plan
- **Reset:** assert `reset` mid-frame (during bit 3) → all outputs 0 within the same cycle. After release with `rx=1` for 200 cycles → `valid=0`, `busy=0`, no pulses.
- **Basic frame:** `ready=1`, send 0xA5 at defaults (start, 8 bits LSB first, stop, 48 cycles each) → `valid` high for exactly 1 cycle with `data=0xA5`. Then send 0x00 and 0xFF back-to-back → both received in order.
- **False start:** drive `rx` low for 10 cycles (< H), then high → `busy` pulses then falls, no `valid`, no `framing_error`.
- **Framing error and break:** send 0x3C with the stop bit low, then hold `rx` low 5 bit times → one `framing_error` pulse, no `valid`, no further pulses. Return `rx` high, then send 0x5A → `data=0x5A`.
- **Overrun:** `ready=0`, send 0x11 then 0x22 → `valid=1` with `data=0x11`, `overrun` pulses once at the second stop sample, `data` stays 0x11. Raise `ready` → `valid` drops the next cycle.
- **Majority:** inject a 1-cycle inverted glitch exactly on the bit-2 sample edge of 0x00.
  - With `UART_RX_MAJORITY_EN`: `data=0x00`.
  - Without it: `data=0x04`.
